router_fsm_ctrl: RTL
====================

# router_fsm_ctrl

Packet-sequencing controller for the 1x3 router input path. It walks each incoming packet through header decode, payload load, FIFO-full stall and parity check. It drives the write-enable qualifier and address-detect strobe consumed by the synchronizer, and the load/state strobes consumed by the register block. It sits between the input port and the synchronizer and reacts to per-FIFO empty and soft-reset status.

## Interface
- No parameters. Address width is fixed at 2 bits and output port count at 3.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- pkt_valid  input  1  packet in progress on the input bus (header through last payload byte).
- data_in  input  2  header destination address bits `[1:0]`, sampled only in DECODE_ADDRESS.
- fifo_full  input  1  full flag of the currently addressed FIFO (from synchronizer).
- fifo_empty_0/1/2  input  1 each  empty flags of output FIFOs 0..2.
- soft_reset_0/1/2  input  1 each  per-FIFO soft-reset pulses (from synchronizer).
- parity_done  input  1  register block has captured the parity byte.
- low_pkt_valid  input  1  register block saw pkt_valid fall while stalled.
- detect_add  output  1  address-capture strobe.
- lfd_state  output  1  load-first-data (header write).
- ld_state  output  1  load payload.
- laf_state  output  1  load-after-full (replay held byte).
- full_state  output  1  stalled on full FIFO.
- write_enb_reg  output  1  FIFO write qualifier.
- rst_int_reg  output  1  clear internal parity/status registers.
- busy  output  1  input must hold data (backpressure to source).

## Operation
- Moore FSM with 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- Internal 2-bit addr_lat register, loaded in DECODE_ADDRESS when pkt_valid=1 and data_in != 2'b11.

Transitions:
- DECODE_ADDRESS:
  - pkt_valid & data_in=n (n in 0..2) & fifo_empty_n → LOAD_FIRST_DATA.
  - pkt_valid & data_in=n & !fifo_empty_n → WAIT_TILL_EMPTY.
  - Otherwise, including data_in=3, stay.
- LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
- LOAD_DATA:
  - fifo_full → FIFO_FULL_STATE.
  - Else !pkt_valid → LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done → DECODE_ADDRESS.
  - Else low_pkt_valid → LOAD_PARITY.
  - Else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR, unconditionally.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE; else → DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty_[addr_lat] → LOAD_FIRST_DATA; else stay.
- Soft reset: in any state except DECODE_ADDRESS, soft_reset_[addr_lat]=1 forces next state DECODE_ADDRESS. This overrides all transitions above. Soft resets of non-addressed FIFOs are ignored. In DECODE_ADDRESS, soft resets have no effect.

Outputs, decoded from the current state only:
- detect_add = DECODE_ADDRESS.
- lfd_state = LOAD_FIRST_DATA.
- ld_state = LOAD_DATA.
- full_state = FIFO_FULL_STATE.
- laf_state = LOAD_AFTER_FULL.
- rst_int_reg = CHECK_PARITY_ERROR.
- write_enb_reg = LOAD_FIRST_DATA | LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY.
- busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- At most one of lfd/ld/laf/full/rst_int_reg/detect_add is high in any cycle.

## Timing
- Priority order: reset, then soft_reset_[addr_lat], then the normal transition.
- Reset (reset=0 at a clk edge) sets state=DECODE_ADDRESS and addr_lat=0. The next cycle then shows detect_add=1, busy=0, and all other outputs 0. This applies mid-packet as well; no partial state survives.
- All outputs are registered-state decodes. An input sampled at edge k changes outputs after edge k, visible in cycle k+1. There is no combinational input-to-output path.
- Header to first write: 1 cycle when the target FIFO is empty (DECODE_ADDRESS → LOAD_FIRST_DATA).
- Parity check: LOAD_PARITY and CHECK_PARITY_ERROR each last exactly 1 cycle.
- fifo_full is sampled only in LOAD_DATA, FIFO_FULL_STATE and CHECK_PARITY_ERROR. It is ignored in other states.
- Simultaneous fifo_full=1 and pkt_valid=0 in LOAD_DATA → FIFO_FULL_STATE (full wins).

## Test plan
- Single packet to port 1 with fifo_empty_1=1, 3 payload bytes, then parity:
  - Required state sequence: DECODE → LFD → LD×3 → LOAD_PARITY → CHECK → DECODE.
  - write_enb_reg high for 5 cycles.
  - busy low only in DECODE and LD.
- Header to port 2 with fifo_empty_2=0 for 4 cycles:
  - Holds WAIT_TILL_EMPTY with busy=1 for those cycles.
  - LFD in the cycle after fifo_empty_2 rises.
- fifo_full=1 during LD for 3 cycles:
  - full_state=1 for 3 cycles, write_enb_reg=0, then laf_state for 1 cycle.
  - With low_pkt_valid=0 and parity_done=0, returns to LD.
- Soft reset: in LD to port 0, pulse soft_reset_0 → DECODE next cycle. A pulse on soft_reset_1 instead has no effect.
- Header data_in=2'b11 with pkt_valid=1 → remains in DECODE with detect_add=1 and addr_lat unchanged.
- reset=0 asserted in FIFO_FULL_STATE → next cycle detect_add=1 and all other outputs 0.

Source files
------------

// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl: packet-sequencing controller for the 1x3 router input path.
// It steps each packet through header decode, first-byte load, payload load,
// the FIFO-full stall/replay and the parity check. Every output is decoded from
// the registered state, so no input reaches an output combinationally.
module router_fsm_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_lat_q, addr_lat_d;

  // Per-port status gathered into vectors. Index 3 is padded with 0 so that a
  // 2-bit address can index them directly; address 3 is never routed.
  logic [3:0] fifo_empty_vec;
  logic [3:0] soft_reset_vec;
  logic       hdr_ok;

  assign fifo_empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_reset_vec = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_ok         = pkt_valid && (data_in != 2'b11);

  // State and latched destination address; active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= DECODE_ADDRESS;
      addr_lat_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_lat_q <= addr_lat_d;
    end
  end

  // Next-state logic: soft reset of the addressed FIFO overrides every normal
  // transition, except in DECODE_ADDRESS where no packet is in flight yet.
  always_comb begin
    state_d    = state_q;
    addr_lat_d = addr_lat_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          addr_lat_d = data_in;
          if (fifo_empty_vec[data_in]) state_d = LOAD_FIRST_DATA;
          else                         state_d = WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        // A full FIFO takes precedence over the end of the packet so the
        // last payload byte is never dropped.
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full) state_d = FIFO_FULL_STATE;
        else           state_d = DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty_vec[addr_lat_q]) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    if ((state_q != DECODE_ADDRESS) && soft_reset_vec[addr_lat_q]) begin
      state_d = DECODE_ADDRESS;
    end
  end

  // Moore output decode from the registered state only.
  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_DATA) ||
                    (state_q == LOAD_AFTER_FULL) || (state_q == LOAD_PARITY);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

endmodule
